// File: rtl/time_sync_stream.sv
// Streaming OFDM timing sync: delay-and-correlate detection, peak search, CP strip.
// Optional metric debug outputs: define TIME_SYNC_METRIC_OUT_EN.
module time_sync_stream #(
  parameter int DATA_W      = 8,
  parameter int FFT_N       = 64,
  parameter int CP_LEN      = 16,
  parameter int N_SYM       = 12,
  parameter int PEAK_WIN    = 16,
  parameter int PAYLOAD_OFS = 112,
  localparam int L          = FFT_N / 2,
  localparam int SUM_W      = 2 * DATA_W + $clog2(L) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic [7:0]               thresh,
  output logic                     m_valid,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_sym_start,
  output logic                     m_last,
  output logic                     sync_lock
`ifdef TIME_SYNC_METRIC_OUT_EN
  ,
  output logic signed [SUM_W-1:0]  dbg_p,
  output logic signed [SUM_W-1:0]  dbg_r,
  output logic                     dbg_valid
`endif
);

  localparam int DEPTH   = 2 * L;
  localparam int PW      = 2 * DATA_W;
  localparam int QW      = 2 * SUM_W;
  localparam int CNT_MAX = DEPTH + PAYLOAD_OFS + FFT_N + CP_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SYM_W   = $clog2(N_SYM + 1);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(PEAK_WIN - 1);
  localparam logic [CNT_W-1:0] WAIT_M1   = CNT_W'(PAYLOAD_OFS - PEAK_WIN - 1);
  localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'(CP_LEN - 1);
  localparam logic [CNT_W-1:0] BODY_LAST = CNT_W'(FFT_N - 1);
  localparam logic [SYM_W-1:0] SYM_ONE   = SYM_W'(1);
  localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(N_SYM - 1);

  typedef enum logic [2:0] {
    FILL,
    SEARCH,
    PEAK,
    WAIT,
    CP,
    PASS
  } state_e;

  logic signed [DATA_W-1:0] dl_q [DEPTH];
  logic signed [SUM_W-1:0]  p_q, p_d;
  logic signed [SUM_W-1:0]  r_q, r_d;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         pos_q, pos_d;
  logic [CNT_W-1:0]         pk_pos;
  logic signed [SUM_W-1:0]  best_q, best_d;
  logic [SYM_W-1:0]         sym_q, sym_d;

  logic                     m_valid_q, m_valid_d;
  logic signed [DATA_W-1:0] m_data_q, m_data_d;
  logic                     m_sos_q, m_sos_d;
  logic                     m_last_q, m_last_d;
  logic                     lock_q, lock_d;

  logic signed [DATA_W-1:0] x_l, x_2l;
  logic signed [PW-1:0]     xn_xl, xl_x2l, xn_sq, xl_sq;
  logic signed [QW-1:0]     p_w, r_w, p_sq, r_sq;
  logic [QW+7:0]            lhs, rhs;
  logic                     detect;

  function automatic logic signed [SUM_W-1:0] ext(
    input logic signed [PW-1:0] v
  );
    return {{(SUM_W - PW){v[PW-1]}}, v};
  endfunction

  assign x_l    = dl_q[L-1];
  assign x_2l   = dl_q[DEPTH-1];
  assign xn_xl  = s_data * x_l;
  assign xl_x2l = x_l * x_2l;
  assign xn_sq  = s_data * s_data;
  assign xl_sq  = x_l * x_l;

  // Running sums: add the newest product, drop the one leaving the window.
  always_comb begin
    p_d = p_q + ext(xn_xl) - ext(xl_x2l);
    r_d = r_q + ext(xn_sq) - ext(xl_sq);
  end

  // Detection compares P^2 and R^2 at full precision, no division.
  always_comb begin
    p_w    = {{SUM_W{p_d[SUM_W-1]}}, p_d};
    r_w    = {{SUM_W{r_d[SUM_W-1]}}, r_d};
    p_sq   = p_w * p_w;
    r_sq   = r_w * r_w;
    lhs    = {p_sq, 8'h00};
    rhs    = {{QW{1'b0}}, thresh} * {8'h00, r_sq};
    detect = !p_d[SUM_W-1] && (p_d != '0) && (r_d != '0) && (lhs >= rhs);
  end

  // Delay line and correlation sums advance on every accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) dl_q[i] <= '0;
      p_q <= '0;
      r_q <= '0;
    end else if (s_valid) begin
      dl_q[0] <= s_data;
      for (int i = 1; i < DEPTH; i++) dl_q[i] <= dl_q[i-1];
      p_q <= p_d;
      r_q <= r_d;
    end
  end

  // Frame FSM: next state, counters and output beat for the current sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pos_d     = pos_q;
    best_d    = best_q;
    sym_d     = sym_q;
    lock_d    = lock_q;
    m_valid_d = 1'b0;
    m_data_d  = m_data_q;
    m_sos_d   = 1'b0;
    m_last_d  = 1'b0;
    pk_pos    = (p_d > best_q) ? cnt_q : pos_q;
    if (s_valid) begin
      unique case (state_q)
        FILL: begin
          if (cnt_q == FILL_LAST) begin
            state_d = SEARCH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        SEARCH: begin
          if (detect) begin
            state_d = PEAK;
            best_d  = p_d;
            pos_d   = '0;
            cnt_d   = ONE;
          end
        end
        PEAK: begin
          pos_d = pk_pos;
          if (p_d > best_q) best_d = p_d;
          if (cnt_q == WIN_LAST) begin
            state_d = WAIT;
            lock_d  = 1'b1;
            cnt_d   = pk_pos + WAIT_M1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_d = CP;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        CP: begin
          if (cnt_q == CP_LAST) begin
            state_d = PASS;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        PASS: begin
          m_valid_d = 1'b1;
          m_data_d  = s_data;
          m_sos_d   = (cnt_q == '0);
          if (cnt_q == BODY_LAST) begin
            cnt_d = '0;
            if (sym_q == SYM_LAST) begin
              m_last_d = 1'b1;
              lock_d   = 1'b0;
              sym_d    = '0;
              state_d  = SEARCH;
            end else begin
              sym_d   = sym_q + SYM_ONE;
              state_d = CP;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      pos_q     <= '0;
      best_q    <= '0;
      sym_q     <= '0;
      lock_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sos_q   <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_q     <= pos_d;
      best_q    <= best_d;
      sym_q     <= sym_d;
      lock_q    <= lock_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sos_q   <= m_sos_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_sym_start = m_sos_q;
  assign m_last      = m_last_q;
  assign sync_lock   = lock_q;

`ifdef TIME_SYNC_METRIC_OUT_EN
  logic signed [SUM_W-1:0] dbg_p_q, dbg_r_q;
  logic                    dbg_v_q;

  // Registered metric taps for every accepted sample past the fill phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_p_q <= '0;
      dbg_r_q <= '0;
      dbg_v_q <= 1'b0;
    end else begin
      dbg_v_q <= s_valid && (state_q != FILL);
      if (s_valid && (state_q != FILL)) begin
        dbg_p_q <= p_d;
        dbg_r_q <= r_d;
      end
    end
  end

  assign dbg_p     = dbg_p_q;
  assign dbg_r     = dbg_r_q;
  assign dbg_valid = dbg_v_q;
`endif

endmodule

// File: tb/tb_time_sync_stream.sv
// Directed bench for time_sync_stream: fill, framed lock, gapped input,
// back-to-back frames, mid-frame reset, and optional metric taps.
module tb_time_sync_stream;

  localparam int NS  = 12;
  localparam int N   = 64;
  localparam int PRE = 175;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic signed [7:0] s_data = '0;
  logic [7:0]        thresh = 8'd230;
  logic              m_valid;
  logic signed [7:0] m_data;
  logic              m_sym_start;
  logic              m_last;
  logic              sync_lock;
`ifdef TIME_SYNC_METRIC_OUT_EN
  logic signed [21:0] dbg_p, dbg_r;
  logic               dbg_valid;
`endif

  time_sync_stream dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .thresh      (thresh),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_sym_start (m_sym_start),
    .m_last      (m_last),
    .sync_lock   (sync_lock)
`ifdef TIME_SYNC_METRIC_OUT_EN
    ,
    .dbg_p       (dbg_p),
    .dbg_r       (dbg_r),
    .dbg_valid   (dbg_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  logic [9:0]        expq[$];
  logic              acc_q = 1'b0;
  logic signed [7:0] dat_q = '0;
  logic              lock_prev = 1'b0;
  int                beats = 0;
  int                lasts = 0;
  int                locks = 0;
  bit                gapm = 0;
  int                gcnt = 0;

  always @(posedge clk) begin
    acc_q <= s_valid & ~rst;
    dat_q <= s_data;
  end

  always @(negedge clk) begin
    lock_prev <= sync_lock;
    if (sync_lock && !lock_prev) locks <= locks + 1;
    if (m_valid) begin
      beats <= beats + 1;
      if (m_last) lasts <= lasts + 1;
      chk("lat", acc_q, 1);
      chk("echo", m_data, dat_q);
      chk("qnonempty", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        chk("data", m_data, $signed(expq[0][7:0]));
        chk("sos", m_sym_start, expq[0][8]);
        chk("last", m_last, expq[0][9]);
        chk("lock", sync_lock, !expq[0][9]);
        void'(expq.pop_front());
      end
    end
  end

  function automatic logic signed [7:0] noise(input int i);
    return 8'((6 * i) % 7 - 3);
  endfunction

  function automatic logic signed [7:0] pre(input int i);
    return (i % 2 == 1) ? -8'sd120 : 8'sd120;
  endfunction

  function automatic logic signed [7:0] body(input int s, input int k);
    int g;
    g = s * N + k;
    return 8'((17 * g + 5) % 121 - 60);
  endfunction

  task automatic step(input logic v, input logic signed [7:0] d);
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic signed [7:0] d);
    step(1'b1, d);
    gcnt++;
    if (gapm && (gcnt % 2 == 0)) step(1'b0, 8'sh55);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    rst = 1'b0;
    expq.delete();
    gcnt = 0;
  endtask

  task automatic send_frame(input int lead, input int abort_beat);
    int b;
    logic [9:0] e;
    b = 0;
    for (int i = 0; i < lead; i++) put(noise(i));
    for (int i = 0; i < PRE; i++) put(pre(i));
    for (int s = 0; s < NS; s++) begin
      for (int j = 0; j < 16; j++) put(body(s, 48 + j));
      for (int k = 0; k < N; k++) begin
        e = {(s == NS - 1 && k == N - 1), (k == 0), body(s, k)};
        expq.push_back(e);
        put(body(s, k));
        if (b == abort_beat) begin
          rst = 1'b1;
          step(1'b1, 8'sd7);
          chk("ab_mv", m_valid, 0);
          chk("ab_md", m_data, 0);
          chk("ab_sos", m_sym_start, 0);
          chk("ab_last", m_last, 0);
          chk("ab_lock", sync_lock, 0);
          rst = 1'b0;
          expq.delete();
          return;
        end
        b++;
      end
    end
    for (int i = 0; i < 50; i++) put('0);
  endtask

  int b0, l0, k0;

  initial begin
    step(1'b0, '0);
    step(1'b0, '0);
    chk("rst_mv", m_valid, 0);
    chk("rst_md", m_data, 0);
    chk("rst_sos", m_sym_start, 0);
    chk("rst_last", m_last, 0);
    chk("rst_lock", sync_lock, 0);
    rst = 1'b0;

    repeat (63) put('0);
    chk("fill63", int'(dut.state_q), 0);
    put('0);
    chk("fill64", int'(dut.state_q), 1);
    repeat (64) put('0);
    chk("z_lock", sync_lock, 0);
    chk("z_beats", beats, 0);

    do_reset();
    b0 = beats; l0 = lasts; k0 = locks;
    send_frame(200, -1);
    chk("f1_beats", beats - b0, 768);
    chk("f1_lasts", lasts - l0, 1);
    chk("f1_locks", locks - k0, 1);
    chk("f1_unlock", sync_lock, 0);
    chk("f1_q", expq.size(), 0);

    do_reset();
    gapm = 1;
    b0 = beats; l0 = lasts; k0 = locks;
    send_frame(200, -1);
    gapm = 0;
    chk("gp_beats", beats - b0, 768);
    chk("gp_lasts", lasts - l0, 1);
    chk("gp_locks", locks - k0, 1);
    chk("gp_q", expq.size(), 0);

    do_reset();
    b0 = beats; l0 = lasts; k0 = locks;
    send_frame(200, -1);
    chk("bb_gap_lock", sync_lock, 0);
    send_frame(0, -1);
    chk("bb_beats", beats - b0, 1536);
    chk("bb_lasts", lasts - l0, 2);
    chk("bb_locks", locks - k0, 2);
    chk("bb_unlock", sync_lock, 0);

    do_reset();
    b0 = beats; l0 = lasts;
    send_frame(200, 300);
    step(1'b0, '0);
    chk("ab_beats", beats - b0, 301);
    chk("ab_nolast", lasts - l0, 0);
    b0 = beats; l0 = lasts; k0 = locks;
    send_frame(200, -1);
    chk("ar_beats", beats - b0, 768);
    chk("ar_lasts", lasts - l0, 1);
    chk("ar_locks", locks - k0, 1);

`ifdef TIME_SYNC_METRIC_OUT_EN
    do_reset();
    repeat (64) put(8'sd10);
    chk("dbg_fill_v", dbg_valid, 0);
    put(8'sd10);
    chk("dbg_v", dbg_valid, 1);
    chk("dbg_p", dbg_p, 3200);
    chk("dbg_r", dbg_r, 3200);
    repeat (5) put(8'sd10);
    chk("dbg_p2", dbg_p, 3200);
    chk("dbg_r2", dbg_r, 3200);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
